// File: rtl/nes_clk_pkg.sv
// Shared constants and FSM state type for the PLL-domain clock-enable logic.
package nes_clk_pkg;

    localparam int unsigned NTSC_CPU_HZ = 1789773;
    localparam int unsigned PAL_CPU_HZ  = 1662607;
    localparam int unsigned PLL_CLK0_HZ = 12000000;

    // Lock qualification states: wait for lock, hold it stable, then run.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } clk_en_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_apu_clock_enable.sv
// Qualifies the PLL lock into a debounced sound-core reset and derives
// exact-rate single-cycle enables (CPU, APU half-rate, audio sample) from
// rational phase accumulators running on the 12 MHz PLL clock.
//
// Handshake-free block: all enables are one-cycle strobes, registered, with
// no back-pressure. Each enable is valid for exactly the cycle it is high.
module nes_apu_clock_enable
    import nes_clk_pkg::*;
#(
    parameter int unsigned CLK_HZ    = PLL_CLK0_HZ,
    parameter int unsigned CPU_HZ    = NTSC_CPU_HZ,
    parameter int unsigned SAMPLE_HZ = 48000,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LOCK_HOLD = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_locked,
    input  logic          pause,
    output logic          sys_rst_n,
    output logic          running,
    output logic          cpu_ce,
    output logic          apu_ce,
    output logic          sample_ce,
    output clk_en_state_t state_dbg
);

    localparam int unsigned CNT_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_HOLD - 1);

    localparam logic [ACC_W-1:0] CLK_STEP = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] CPU_STEP = ACC_W'(CPU_HZ);
    localparam logic [ACC_W-1:0] SMP_STEP = ACC_W'(SAMPLE_HZ);

    logic              lock_s;
    clk_en_state_t     state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic [ACC_W-1:0]  cpu_acc, cpu_sum;
    logic [ACC_W-1:0]  smp_acc, smp_sum;
    logic              cpu_ovf, smp_ovf;
    logic              apu_tgl;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign state_dbg = state;

    // State and hold-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; a low lock_s always wins, even over hold completion.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Reset and running flags follow the next state so they move on the
    // same edge as the state register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n <= 1'b0;
            running   <= 1'b0;
        end else begin
            sys_rst_n <= (state_next == ST_RUN);
            running   <= (state_next == ST_RUN);
        end
    end

    // Phase sums; CLK_HZ + RATE < 2*CLK_HZ so no wrap is possible.
    always_comb begin
        cpu_sum = cpu_acc + CPU_STEP;
        smp_sum = smp_acc + SMP_STEP;
        cpu_ovf = (cpu_sum >= CLK_STEP);
        smp_ovf = (smp_sum >= CLK_STEP);
    end

    // Accumulators and enables: step on every unpaused edge that lands in
    // RUN, hold while paused, clear whenever RUN is left or not reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_acc   <= '0;
            smp_acc   <= '0;
            apu_tgl   <= 1'b0;
            cpu_ce    <= 1'b0;
            apu_ce    <= 1'b0;
            sample_ce <= 1'b0;
        end else if (state_next != ST_RUN) begin
            cpu_acc   <= '0;
            smp_acc   <= '0;
            apu_tgl   <= 1'b0;
            cpu_ce    <= 1'b0;
            apu_ce    <= 1'b0;
            sample_ce <= 1'b0;
        end else if (pause) begin
            cpu_ce    <= 1'b0;
            apu_ce    <= 1'b0;
            sample_ce <= 1'b0;
        end else begin
            cpu_acc   <= cpu_ovf ? (cpu_sum - CLK_STEP) : cpu_sum;
            smp_acc   <= smp_ovf ? (smp_sum - CLK_STEP) : smp_sum;
            apu_tgl   <= apu_tgl ^ cpu_ovf;
            cpu_ce    <= cpu_ovf;
            apu_ce    <= cpu_ovf & ~apu_tgl;
            sample_ce <= smp_ovf;
        end
    end

endmodule

// File: tb/tb_nes_apu_clock_enable.sv
// Bench for nes_apu_clock_enable with a small rational configuration.
module tb_nes_apu_clock_enable;

    localparam int CLK_HZ    = 10;
    localparam int CPU_HZ    = 3;
    localparam int SAMPLE_HZ = 4;
    localparam int ACC_W     = 8;
    localparam int LOCK_HOLD = 4;
    localparam int LOCK_LAT  = 2 + LOCK_HOLD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
    logic pause = 1'b0;
    logic sys_rst_n, running, cpu_ce, apu_ce, sample_ce;
    nes_clk_pkg::clk_en_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: m = number of unpaused stepping edges since RUN entry.
    int   m;
    logic exp_cpu, exp_apu, exp_smp;
    int   obs_cpu, obs_apu, obs_smp;

    nes_apu_clock_enable #(
        .CLK_HZ    (CLK_HZ),
        .CPU_HZ    (CPU_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .ACC_W     (ACC_W),
        .LOCK_HOLD (LOCK_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pause      (pause),
        .sys_rst_n  (sys_rst_n),
        .running    (running),
        .cpu_ce     (cpu_ce),
        .apu_ce     (apu_ce),
        .sample_ce  (sample_ce),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A pulse after step s exists when s*rate/CLK_HZ crosses an integer.
    function automatic logic crossed(input int s, input int rate);
        return (s > 0) && ((s * rate) / CLK_HZ != ((s - 1) * rate) / CLK_HZ);
    endfunction

    task automatic advance_model(input logic p);
        if (p) begin
            exp_cpu = 1'b0;
            exp_apu = 1'b0;
            exp_smp = 1'b0;
        end else begin
            m++;
            exp_cpu = crossed(m, CPU_HZ);
            // apu accompanies the 1st, 3rd, 5th ... cpu pulse.
            exp_apu = exp_cpu && (((m * CPU_HZ) / CLK_HZ) % 2 == 1);
            exp_smp = crossed(m, SAMPLE_HZ);
        end
    endtask

    // Driver: the RUN-entry edge is the first stepping edge.
    task automatic model_enter_run();
        m = 0;
        advance_model(1'b0);
        obs_cpu = 0;
        obs_apu = 0;
        obs_smp = 0;
    endtask

    // Driver + model: check current cycle, pick pause, pass one edge.
    task automatic run_model(input string name, input int n, input int ps,
                             input int pl, input bit rnd);
        logic p;
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({cpu_ce, apu_ce, sample_ce, running, sys_rst_n} !==
                {exp_cpu, exp_apu, exp_smp, 2'b11}) begin
                errors++;
                $display("FAIL %s cycle %0d: cpu/apu/smp/run/rst = %b%b%b%b%b, expected %b%b%b11",
                         name, i, cpu_ce, apu_ce, sample_ce, running, sys_rst_n,
                         exp_cpu, exp_apu, exp_smp);
            end
            obs_cpu += int'(cpu_ce);
            obs_apu += int'(apu_ce);
            obs_smp += int'(sample_ce);
            p = rnd ? ($urandom_range(0, 3) == 0) : (i >= ps && i < ps + pl);
            pause = p;
            @(negedge clk);
            advance_model(p);
        end
        pause = 1'b0;
    endtask

    // Driver: raise lock and expect RUN exactly LOCK_LAT edges later.
    task automatic acquire_lock(input string name);
        logic exp_r;
        pll_locked = 1'b1;
        for (int e = 0; e <= LOCK_LAT; e++) begin
            @(negedge clk);
            exp_r = (e >= LOCK_LAT);
            checks++;
            if (running !== exp_r || sys_rst_n !== exp_r ||
                {cpu_ce, apu_ce, sample_ce} !== 3'b000) begin
                errors++;
                $display("FAIL %s edge %0d: run=%b rst=%b ce=%b%b%b, expected run=rst=%b ce=000",
                         name, e, running, sys_rst_n, cpu_ce, apu_ce, sample_ce, exp_r);
            end
        end
        model_enter_run();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({sys_rst_n, running, cpu_ce, apu_ce, sample_ce} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: outputs=%b, expected 00000", i,
                         {sys_rst_n, running, cpu_ce, apu_ce, sample_ce});
            end
        end
        pll_locked = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({sys_rst_n, running, cpu_ce, apu_ce, sample_ce} !== 5'b0) begin
                errors++;
                $display("FAIL unlocked_idle cycle %0d: outputs=%b, expected 00000", i,
                         {sys_rst_n, running, cpu_ce, apu_ce, sample_ce});
            end
        end
    endtask

    task automatic test_lock_sequence();
        // Lock rises at cycle 10 of the unlocked interval.
        repeat (4) @(negedge clk);
        acquire_lock("lock_seq");
    endtask

    task automatic test_rational_stepping();
        int pos;
        int cpu_at[$];
        int apu_at[$];
        // Explicit pattern over the first 10 RUN cycles: cpu at 4,7,10, apu at 4,10.
        for (int c = 1; c <= 10; c++) begin
            if (cpu_ce === 1'b1) cpu_at.push_back(c);
            if (apu_ce === 1'b1) apu_at.push_back(c);
            @(negedge clk);
            advance_model(1'b0);
        end
        checks++;
        if (cpu_at.size() != 3 || cpu_at[0] != 4 || cpu_at[1] != 7 || cpu_at[2] != 10) begin
            errors++;
            $display("FAIL step_cpu_pattern: got %p, expected '{4, 7, 10}", cpu_at);
        end
        checks++;
        if (apu_at.size() != 2 || apu_at[0] != 4 || apu_at[1] != 10) begin
            errors++;
            $display("FAIL step_apu_pattern: got %p, expected '{4, 10}", apu_at);
        end
        pos = m;
        run_model("step_repeat", 30, 0, 0, 1'b0);
        checks++;
        if (obs_cpu != ((pos + 30) * CPU_HZ) / CLK_HZ - (pos * CPU_HZ) / CLK_HZ) begin
            errors++;
            $display("FAIL step_repeat_count: got %0d cpu pulses, expected 9", obs_cpu);
        end
    endtask

    task automatic test_pause();
        hard_reset();
        acquire_lock("pause_lock");
        // Pause 7 edges starting after RUN cycle 2: pulses move 4,7,10 -> 11,14,17.
        run_model("pause7", 40, 1, 7, 1'b0);
        run_model("pause_rand", 200, 0, 0, 1'b1);
    endtask

    task automatic test_exactness();
        hard_reset();
        acquire_lock("exact_lock");
        run_model("exact", 1000, 0, 0, 1'b0);
        checks++;
        if (obs_cpu != 1000 * CPU_HZ / CLK_HZ) begin
            errors++;
            $display("FAIL exact_cpu: got %0d, expected %0d", obs_cpu, 1000 * CPU_HZ / CLK_HZ);
        end
        checks++;
        if (obs_smp != 1000 * SAMPLE_HZ / CLK_HZ) begin
            errors++;
            $display("FAIL exact_sample: got %0d, expected %0d", obs_smp, 1000 * SAMPLE_HZ / CLK_HZ);
        end
        checks++;
        if (obs_apu != 1000 * CPU_HZ / CLK_HZ / 2) begin
            errors++;
            $display("FAIL exact_apu: got %0d, expected %0d", obs_apu, 1000 * CPU_HZ / CLK_HZ / 2);
        end
    endtask

    task automatic test_hold_glitch();
        logic exp_r;
        hard_reset();
        pll_locked = 1'b1;
        // Drop lock for 3 edges mid-HOLD; RUN only after a full fresh sequence.
        for (int e = 0; e <= 7 + LOCK_LAT; e++) begin
            @(negedge clk);
            exp_r = (e >= 7 + LOCK_LAT);
            checks++;
            if (running !== exp_r || sys_rst_n !== exp_r) begin
                errors++;
                $display("FAIL hold_glitch edge %0d: run=%b rst=%b, expected %b",
                         e, running, sys_rst_n, exp_r);
            end
            if (e == 3) pll_locked = 1'b0;
            if (e == 6) pll_locked = 1'b1;
        end
        model_enter_run();
        run_model("glitch_run", 12, 0, 0, 1'b0);
    endtask

    task automatic test_lock_loss();
        int first_cpu;
        run_model("loss_pre", 5, 0, 0, 1'b0);
        pll_locked = 1'b0;
        run_model("loss_lag", 2, 0, 0, 1'b0);
        checks++;
        if ({cpu_ce, apu_ce, sample_ce, running, sys_rst_n} !==
            {exp_cpu, exp_apu, exp_smp, 2'b11}) begin
            errors++;
            $display("FAIL loss_last_run: outputs=%b%b%b%b%b, expected %b%b%b11",
                     cpu_ce, apu_ce, sample_ce, running, sys_rst_n, exp_cpu, exp_apu, exp_smp);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ce, apu_ce, sample_ce, running, sys_rst_n} !== 5'b0) begin
            errors++;
            $display("FAIL loss_drop: outputs=%b, expected 00000",
                     {cpu_ce, apu_ce, sample_ce, running, sys_rst_n});
        end
        acquire_lock("relock");
        first_cpu = 0;
        for (int c = 1; c <= 12 && first_cpu == 0; c++) begin
            if (cpu_ce === 1'b1) begin
                first_cpu = c;
                checks++;
                if (apu_ce !== 1'b1 || c != 4) begin
                    errors++;
                    $display("FAIL relock_first_cpu: cycle %0d apu=%b, expected cycle 4 apu=1",
                             c, apu_ce);
                end
            end
            @(negedge clk);
            advance_model(1'b0);
        end
        checks++;
        if (first_cpu == 0) begin
            errors++;
            $display("FAIL relock_no_cpu: got no cpu_ce, expected one by cycle 4");
        end
        run_model("relock_run", 20, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        run_model("rst_pre", 6, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sys_rst_n, running, cpu_ce, apu_ce, sample_ce} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async: outputs=%b, expected 00000",
                     {sys_rst_n, running, cpu_ce, apu_ce, sample_ce});
        end
        @(negedge clk);
        rst_n = 1'b1;
        acquire_lock("rst_relock");
        run_model("rst_run", 15, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_rational_stepping();
        test_pause();
        test_exactness();
        test_hold_glitch();
        test_lock_loss();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_apu_clock_enable.md
# nes_apu_clock_enable

Sits directly downstream of the 50 MHz-to-12/13.3/14.3 MHz PLL wrapper and runs on its 12 MHz output clock. It qualifies the PLL `locked` flag into a clean, debounced system reset. It then derives exact-rate single-cycle clock enables for the NES CPU/APU core (1.789773 MHz NTSC), the APU frame half-rate, and the audio sample rate, using rational phase accumulators. All sound-core logic runs on `clk` and is gated by these enables; no derived clocks are created.

## Interface
- `CLK_HZ`, 12000000: frequency of `clk`, in Hz.
- `CPU_HZ`, 1789773: target rate of `cpu_ce`; must be < `CLK_HZ`.
- `SAMPLE_HZ`, 48000: target rate of `sample_ce`; must be < `CLK_HZ`.
- `ACC_W`, 32: accumulator width; must hold `2*CLK_HZ`.
- `LOCK_HOLD`, 1024: number of `clk` cycles the synchronized lock must stay high before reset is released; ≥1.
- `clk` in 1: 12 MHz PLL output (outclk_0 domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked` flag, asynchronous to `clk`.
- `pause` in 1: when high in RUN, freezes both accumulators and suppresses all enables.
- `sys_rst_n` out 1: active-low reset for the sound core; asserts asynchronously with `rst_n`, deasserts synchronously.
- `running` out 1: high while state is RUN.
- `cpu_ce` out 1: one-cycle pulse at the `CPU_HZ` average rate.
- `apu_ce` out 1: pulse coincident with every second `cpu_ce`.
- `sample_ce` out 1: one-cycle pulse at the `SAMPLE_HZ` average rate.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `lock_s`; reset value 0.
- FSM states: WAIT_LOCK (reset state), HOLD, RUN.
  - WAIT_LOCK → HOLD when `lock_s`=1. The hold counter is cleared on entry.
  - HOLD: the counter increments each cycle. When counter = `LOCK_HOLD`-1 and `lock_s`=1, go to RUN. If `lock_s`=0, go to WAIT_LOCK.
  - RUN: if `lock_s`=0, go to WAIT_LOCK.
  - Lock loss takes priority over every other event, including hold completion in the same cycle.
- Accumulator step (CPU and SAMPLE accumulators identical, each with its own `*_HZ`): `sum = acc + RATE_HZ`.
  - If `sum ≥ CLK_HZ`: `acc ← sum − CLK_HZ` and pulse.
  - Otherwise: `acc ← sum`, no pulse.
  - All arithmetic is unsigned `ACC_W`; no wrap ever occurs.
- Accumulators step only in RUN with `pause`=0.
- Accumulators, the apu toggle, and all enables are cleared to 0 on any exit from RUN and held at 0 outside RUN.
- apu toggle: flips on each `cpu_ce`. `apu_ce` = cpu overflow AND toggle==0, so the first `cpu_ce` after entering RUN also produces `apu_ce`.
- Exactness requirement: over any `CLK_HZ` consecutive unpaused RUN cycles starting from acc=0, exactly `CPU_HZ` cpu pulses and `SAMPLE_HZ` sample pulses occur.

## Timing
- Reset values of all outputs are 0, as are the state (WAIT_LOCK), counter, accumulators, and toggle.
- `pll_locked` rises before edge k → `lock_s`=1 after edge k+1 → HOLD after edge k+2.
- RUN is entered at edge k+2+`LOCK_HOLD`. `sys_rst_n` and `running` are both registered from the next-state value, so they rise at that same edge.
- Lock loss: `lock_s` falls 2 edges after `pll_locked` falls. `sys_rst_n`, `running`, and the enables go low at the following edge.
- Enable latency: the overflow computed in RUN cycle n appears registered on the output during cycle n+1, i.e. in the cycle after the stepping edge.
- `pause` is sampled each edge. While paused, enables are 0 and the accumulator values are retained. Resume continues the sequence exactly.
- `rst_n` low mid-RUN: all outputs go to 0 immediately (asynchronously). After release, the full lock sequence restarts.

## Structure
- Shared package `nes_clk_pkg` holds:
  - Constants `NTSC_CPU_HZ`=1789773, `PAL_CPU_HZ`=1662607, `PLL_CLK0_HZ`=12000000.
  - The FSM state enum `clk_en_state_t`.
- Sub-module `sync_2ff` provides the single-bit synchronizer with async active-low reset. It is reused elsewhere for other PLL-domain crossings.
- The accumulator is inline logic, instantiated twice via generate or as duplicated logic. It is not a separate module.

## Test plan
- **Lock sequence:** `LOCK_HOLD`=4; raise `pll_locked` at cycle 10 → `sys_rst_n`/`running` rise exactly 6 edges later; no enable pulses before then.
- **Rational stepping:** `CLK_HZ`=10, `CPU_HZ`=3 → `cpu_ce` at RUN cycles 4, 7, 10 (1-indexed, output lag included). `apu_ce` accompanies the pulses at 4 and 10 only. The pattern repeats every 10 cycles.
- **Long-run exactness:** default parameters over 12,000,000 RUN cycles → exactly 1,789,773 `cpu_ce` and exactly 48,000 `sample_ce`; never two `cpu_ce` in consecutive cycles.
- **Hold glitch:** drop `pll_locked` for 3 cycles mid-HOLD → return to WAIT_LOCK; the counter restarts and the full `LOCK_HOLD` is required again.
- **Lock loss mid-RUN:** `sys_rst_n` and the enables go low 3 edges after the `pll_locked` fall. After relock, the first `cpu_ce` is paired with `apu_ce` and the accumulators restart from 0.
- **Pause and reset:** pausing for 7 cycles shifts the pulse train by exactly 7 cycles with unchanged spacing. Asserting `rst_n` mid-RUN zeroes all outputs within the same cycle.
